logic_fold_unit: RTL and testbench

LOGIC_FOLD_UNIT -- requirements
Module: logic_fold_unit

---
 rtl/logic_fold_unit.sv | 145 ++++++++++++++
 tb/tb_logic_fold_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_fold_unit.sv
// logic_fold_unit: applies a per-beat bitwise op to (va, vb) and folds the beats of
// a packet into one result, presented with a valid/ready handshake.
module logic_fold_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [2:0]       op,
  input  logic [1:0]       fold,
  input  logic [WIDTH-1:0] va,
  input  logic [WIDTH-1:0] vb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] vy,
  output logic             y,
  output logic [CNT_W-1:0] beats
);

  typedef enum logic [1:0] {IDLE = 2'b00, ACC = 2'b01, OUT = 2'b10} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s, vy_r, vy_s, f_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, beats_r, beats_s;
  logic [1:0]       fold_r, fold_s;
  logic             out_valid_r, y_r;
  logic             start_s, cont_s;

  function automatic logic [WIDTH-1:0] beat_op(input logic [2:0] o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (o)
      3'b000:  beat_op = a & b;
      3'b001:  beat_op = a | b;
      3'b010:  beat_op = a ^ b;
      3'b011:  beat_op = ~(a & b);
      3'b100:  beat_op = ~(a | b);
      3'b101:  beat_op = ~(a ^ b);
      3'b110:  beat_op = a & ~b;
      default: beat_op = a;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] fold_op(input logic [1:0] fo,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] x);
    case (fo)
      2'b00:   fold_op = acc & x;
      2'b01:   fold_op = acc | x;
      2'b10:   fold_op = acc ^ x;
      default: fold_op = x;
    endcase
  endfunction

  assign f_s      = beat_op(op, va, vb);
  // A held result only makes room for a new beat when the consumer takes it.
  assign in_ready = (state_r == OUT) ? out_ready : 1'b1;

  // Next-state: classify the beat as packet start or continuation, then update.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    fold_s  = fold_r;
    vy_s    = vy_r;
    beats_s = beats_r;
    start_s = 1'b0;
    cont_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) start_s = 1'b1;
        else          start_s = 1'b0;
      end
      ACC: begin
        if (in_valid) cont_s = 1'b1;
        else          cont_s = 1'b0;
      end
      OUT: begin
        if (out_ready && in_valid) start_s = 1'b1;
        else if (out_ready)        state_s = IDLE;
        else                       state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
    if (start_s) begin
      acc_s  = f_s;
      cnt_s  = CNT_W'(1'b1);
      fold_s = fold;
    end else if (cont_s) begin
      acc_s  = fold_op(fold_r, acc_r, f_s);
      cnt_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1'b1);
      fold_s = fold_r;
    end else begin
      acc_s  = acc_r;
      cnt_s  = cnt_r;
      fold_s = fold_r;
    end
    if (start_s || cont_s) begin
      if (in_last) begin
        vy_s    = acc_s;
        beats_s = cnt_s;
        state_s = OUT;
      end else begin
        state_s = ACC;
      end
    end else begin
      vy_s    = vy_r;
      beats_s = beats_r;
    end
  end

  // State, accumulator and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      fold_r      <= 2'b00;
      vy_r        <= {WIDTH{1'b0}};
      beats_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      y_r         <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      fold_r      <= fold_s;
      vy_r        <= vy_s;
      beats_r     <= beats_s;
      out_valid_r <= (state_s == OUT);
      y_r         <= &vy_s;
    end
  end

  assign vy        = vy_r;
  assign y         = y_r;
  assign beats     = beats_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_logic_fold_unit.sv
// Randomized scoreboard bench for logic_fold_unit (WIDTH=4, CNT_W=2 so saturation is reachable).
module tb_logic_fold_unit;
  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [1:0]    fold = 2'b00;
  logic [W-1:0]  va = '0, vb = '0;
  logic          in_ready, out_valid, y;
  logic [W-1:0]  vy;
  logic [CW-1:0] beats;

  int n_pass = 0, n_total = 0, n_out = 0;
  logic [W-1:0] exp_vy_q[$];
  int           exp_beats_q[$];
  logic [W-1:0] pkt_q[$];
  logic [1:0]   pkt_fold = 2'b00;
  bit           rnd_ready = 1'b0;

  logic_fold_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op(op), .fold(fold), .va(va), .vb(vb),
    .out_valid(out_valid), .out_ready(out_ready), .vy(vy), .y(y), .beats(beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] ref_op(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // Reduce the stored beat values of the packet with the fold chosen on its first beat.
  function automatic logic [W-1:0] fold_packet();
    logic [W-1:0] r = pkt_q[0];
    for (int i = 1; i < pkt_q.size(); i++) begin
      case (pkt_fold)
        2'b00:   r = r & pkt_q[i];
        2'b01:   r = r | pkt_q[i];
        2'b10:   r = r ^ pkt_q[i];
        default: r = pkt_q[i];
      endcase
    end
    return r;
  endfunction

  task automatic send_beat(input int o, input int fd, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit last, output int waits);
    bit ok;
    op = 3'(o); fold = 2'(fd); va = a; vb = b; in_last = last; in_valid = 1'b1;
    waits = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      if (ok) break;
      waits++;
      if (waits > 200) begin
        n_total++;
        $display("FAIL send_timeout: waited %0d cycles, expected acceptance within 200", waits);
        break;
      end
    end
    if (ok) begin
      if (pkt_q.size() == 0) pkt_fold = 2'(fd);
      pkt_q.push_back(ref_op(o, a, b));
      if (last) begin
        exp_vy_q.push_back(fold_packet());
        exp_beats_q.push_back((pkt_q.size() > CMAX) ? CMAX : pkt_q.size());
        pkt_q.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: compare every completed output handshake with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_vy_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got vy=%0h beats=%0d, expected no result", vy, beats);
      end else begin
        logic [W-1:0] ev;
        int           eb;
        ev = exp_vy_q.pop_front();
        eb = exp_beats_q.pop_front();
        chk("sb_vy", vy, ev);
        chk("sb_beats", beats, eb);
        chk("sb_y", y, &ev);
        n_out++;
      end
    end
  end

  initial begin
    int w, base, len;
    logic [W-1:0] a;
    #12;
    chk("rst_vy", vy, 0); chk("rst_y", y, 0); chk("rst_beats", beats, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single beat AND packet
    out_ready = 1'b1;
    send_beat(0, 0, 4'b1010, 4'b1111, 1'b1, w);
    chk("single_valid", out_valid, 1); chk("single_vy", vy, 4'b1010);
    chk("single_y", y, 0); chk("single_beats", beats, 1);
    idle(2);

    // Three-beat OR fold of pass-va; fold input on later beats must be ignored
    send_beat(7, 1, 4'b0001, 4'b0000, 1'b0, w); chk("or3_valid_b1", out_valid, 0);
    send_beat(7, 0, 4'b0100, 4'b1111, 1'b0, w); chk("or3_valid_b2", out_valid, 0);
    send_beat(7, 0, 4'b1000, 4'b0000, 1'b1, w); chk("or3_valid_b3", out_valid, 1);
    chk("or3_vy", vy, 4'b1101); chk("or3_beats", beats, 3);
    idle(2);

    // Backpressure: held result blocks input, then retires as the next beat enters
    out_ready = 1'b0;
    send_beat(0, 0, 4'b1100, 4'b1010, 1'b1, w);
    op = 3'd5; va = 4'b0110; vb = 4'b0011; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0); chk("bp_vy", vy, 4'b1000);
      chk("bp_beats", beats, 1); chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_beat(5, 0, 4'b0110, 4'b0011, 1'b1, w);
    chk("bp_same_edge_accept", w, 0);
    chk("bp_new_vy", vy, 4'b1010);
    idle(2);

    // Five-beat XOR of all-ones saturates the beat count
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom);
      send_beat(2, (i == 0) ? 2 : int'($urandom_range(0, 3)), a, ~a, i == 4, w);
    end
    chk("sat_vy", vy, 4'b1111); chk("sat_y", y, 1); chk("sat_beats", beats, CMAX);
    idle(2);

    // Reset in the middle of an open packet
    send_beat(1, 0, W'($urandom), W'($urandom), 1'b0, w);
    send_beat(1, 0, W'($urandom), W'($urandom), 1'b0, w);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vy", vy, 0); chk("mid_rst_y", y, 0);
    chk("mid_rst_beats", beats, 0); chk("mid_rst_out_valid", out_valid, 0);
    pkt_q.delete(); exp_vy_q.delete(); exp_beats_q.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1); chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    send_beat(3, 0, 4'b0000, 4'b0000, 1'b1, w);
    chk("post_rst_vy", vy, 4'b1111); chk("post_rst_y", y, 1); chk("post_rst_beats", beats, 1);
    idle(2);

    // Back-to-back single-beat packets, one per cycle
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      send_beat(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'b1, w);
      chk("b2b_no_stall", w, 0);
    end
    idle(2);
    chk("b2b_results", n_out - base, 10);

    // Random packets with random consumer backpressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++)
        send_beat(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  W'($urandom), W'($urandom), i == len - 1, w);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("drain_pending", exp_vy_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
